// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the fetch PC, issues one BRAM read per cycle when the
// 2-entry output queue has room, and squashes wrong-path fetches on a redirect.
module fetch_sequencer #(
    parameter int unsigned     PC_W     = 9,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_fetch_en,
    output logic               o_imem_en,
    output logic [PC_W-3:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr,
    input  logic               i_ready,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [PC_W-1:0] AlignMask = ~PC_W'(3);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]      inflight_pc_q, inflight_pc_d;
    logic                 inflight_q, inflight_d;
    logic                 drop_q, drop_d;
    logic [1:0]           occ_q, occ_d;
    logic [PC_W-1:0]      head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [INSTR_W-1:0]   head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;

    logic                 deq;
    logic                 push;
    logic                 issue;
    logic [2:0]           pending;
    logic [1:0]           base;

    assign deq     = (occ_q != 2'd0) && i_ready;
    assign push    = inflight_q && !drop_q && !i_redirect_valid;
    // Slots that will be claimed after this edge: queued + in flight - leaving.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign issue   = (state_q == StRun) && i_fetch_en && !i_redirect_valid && (pending < 3'd2);

    assign o_imem_en   = issue;
    assign o_imem_addr = fetch_pc_q[PC_W-1:2];
    assign o_valid     = (occ_q != 2'd0);
    assign o_pc        = head_pc_q;
    assign o_instr     = head_instr_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        drop_d        = 1'b0;
        occ_d         = occ_q;
        head_pc_d     = head_pc_q;
        head_instr_d  = head_instr_q;
        tail_pc_d     = tail_pc_q;
        tail_instr_d  = tail_instr_q;
        base          = occ_q - {1'b0, deq};

        unique case (state_q)
            StIdle:  if (i_fetch_en)  state_d = StRun;
            StRun:   if (!i_fetch_en) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_W'(4);
        end

        if (i_redirect_valid) begin
            fetch_pc_d = i_redirect_pc & AlignMask;
            drop_d     = inflight_q;
            occ_d      = 2'd0;
        end else begin
            if (deq && occ_q == 2'd2) begin
                head_pc_d    = tail_pc_q;
                head_instr_d = tail_instr_q;
            end
            if (push) begin
                if (base == 2'd0) begin
                    head_pc_d    = inflight_pc_q;
                    head_instr_d = i_imem_rdata;
                end else begin
                    tail_pc_d    = inflight_pc_q;
                    tail_instr_d = i_imem_rdata;
                end
            end
            occ_d = base + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC & AlignMask;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            drop_q        <= 1'b0;
            occ_q         <= 2'd0;
            head_pc_q     <= '0;
            head_instr_q  <= '0;
            tail_pc_q     <= '0;
            tail_instr_q  <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            occ_q         <= occ_d;
            head_pc_q     <= head_pc_d;
            head_instr_q  <= head_instr_d;
            tail_pc_q     <= tail_pc_d;
            tail_instr_q  <= tail_instr_d;
        end
    end

endmodule
